// File: rtl/vrf_pkg.sv
// Shared types and constants for the vector register file read scheduler.
//
// The type widths describe the default configuration. The scheduler's
// parameters default to these values, and the per-port route record uses
// these types directly.
package vrf_pkg;

    localparam int VRF_PORT_NUM       = 5;
    localparam int VRF_BANK_NUM       = 4;
    localparam int VRF_BANK_READ_PORT = 2;
    localparam int VRF_ADDR_WIDTH     = 6;
    localparam int VRF_DATA_WIDTH     = 128;
    localparam int VRF_BANK_SEL_WIDTH = $clog2(VRF_BANK_NUM);
    localparam int VRF_ROW_WIDTH      = VRF_ADDR_WIDTH - VRF_BANK_SEL_WIDTH;
    // A single-port bank still needs a 1-bit slot id so the route record stays legal.
    localparam int VRF_SLOT_ID_WIDTH  = (VRF_BANK_READ_PORT > 1) ? $clog2(VRF_BANK_READ_PORT) : 1;

    // Arbitration modes
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef logic [VRF_ADDR_WIDTH-1:0]     vreg_addr_t;
    typedef logic [VRF_ROW_WIDTH-1:0]      row_t;
    typedef logic [VRF_BANK_SEL_WIDTH-1:0] bank_id_t;
    typedef logic [VRF_SLOT_ID_WIDTH-1:0]  slot_id_t;

    // Where a granted request's data will come from once the bank answers.
    typedef struct packed {
        logic     valid;
        bank_id_t bank;
        slot_id_t slot;
    } route_t;

endpackage

// File: rtl/vrf_bank_slot_alloc.sv
// Per-bank slot allocator (purely combinational).
//
// Scans the requesting ports in rotating order starting at ptr (or at port 0
// in fixed mode). A port whose row already occupies a slot rides along on that
// slot; otherwise it takes the next free slot, lowest index first. Ports that
// find neither are not granted.
//
// Ports:
//   hit      in   ports with a valid request addressed to this bank
//   row      in   row index of every port's request
//   ptr      in   current scan start (round-robin pointer)
//   grant    out  per-port grant
//   slot_id  out  per-port slot the granted request is served from
//   slot_en  out  slot allocated this cycle
//   slot_row out  row read through each allocated slot (0 when unallocated)
//   ptr_next out  scan start for the next cycle (equals ptr if nothing granted)
module vrf_bank_slot_alloc
    import vrf_pkg::*;
#(
    parameter int PORT_NUM       = VRF_PORT_NUM,
    parameter int BANK_READ_PORT = VRF_BANK_READ_PORT,
    parameter int ROW_WIDTH      = VRF_ROW_WIDTH,
    parameter int SLOT_ID_WIDTH  = VRF_SLOT_ID_WIDTH,
    parameter int PTR_WIDTH      = 3,
    parameter int ARB_MODE       = ARB_RR
) (
    input  logic [PORT_NUM-1:0]                      hit,
    input  logic [PORT_NUM-1:0][ROW_WIDTH-1:0]       row,
    input  logic [PTR_WIDTH-1:0]                     ptr,
    output logic [PORT_NUM-1:0]                      grant,
    output logic [PORT_NUM-1:0][SLOT_ID_WIDTH-1:0]   slot_id,
    output logic [BANK_READ_PORT-1:0]                slot_en,
    output logic [BANK_READ_PORT-1:0][ROW_WIDTH-1:0] slot_row,
    output logic [PTR_WIDTH-1:0]                     ptr_next
);

    always_comb begin
        int   start;
        int   p;
        int   used;
        logic merged;

        grant    = '0;
        slot_id  = '0;
        slot_en  = '0;
        slot_row = '0;
        ptr_next = ptr;
        used     = 0;
        merged   = 1'b0;
        p        = 0;
        start    = (ARB_MODE == ARB_FIXED) ? 0 : int'(ptr);

        for (int k = 0; k < PORT_NUM; k++) begin
            // Wrap the scan index back into the port range.
            p = start + k;
            if (p >= PORT_NUM) begin
                p = p - PORT_NUM;
            end

            if (hit[p]) begin
                merged = 1'b0;
                for (int s = 0; s < BANK_READ_PORT; s++) begin
                    if (!merged && slot_en[s] && (slot_row[s] == row[p])) begin
                        merged     = 1'b1;
                        grant[p]   = 1'b1;
                        slot_id[p] = SLOT_ID_WIDTH'(s);
                    end
                end

                if (!merged && (used < BANK_READ_PORT)) begin
                    slot_en[used]  = 1'b1;
                    slot_row[used] = row[p];
                    grant[p]       = 1'b1;
                    slot_id[p]     = SLOT_ID_WIDTH'(used);
                    used           = used + 1;
                end

                // The last granted port in scan order decides where the next scan starts.
                if (grant[p]) begin
                    ptr_next = (p == PORT_NUM - 1) ? '0 : PTR_WIDTH'(p + 1);
                end
            end
        end
    end

endmodule

// File: rtl/vrf_bank_read_scheduler.sv
// Banked vector register file read scheduler.
//
// Arbitrates PORT_NUM read requests across BANK_NUM banks that each have
// BANK_READ_PORT read ports. Requests to the same row of a bank share one bank
// port. Accepted requests see their data on rsp_data exactly three cycles
// after the handshake, and a new request may issue every cycle.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     per-port read request
//   req_addr      per-port vreg address (low bits select the bank)
//   req_ready     per-port grant this cycle (combinational)
//   bank_rd_en    registered bank read enable per bank slot
//   bank_rd_row   registered row index per bank slot
//   bank_rd_data  bank read data, valid the cycle after bank_rd_en
//   rsp_valid     per-port response valid
//   rsp_data      per-port response data (holds when no response)
module vrf_bank_read_scheduler
    import vrf_pkg::*;
#(
    parameter int PORT_NUM       = VRF_PORT_NUM,
    parameter int BANK_NUM       = VRF_BANK_NUM,
    parameter int BANK_READ_PORT = VRF_BANK_READ_PORT,
    parameter int ADDR_WIDTH     = VRF_ADDR_WIDTH,
    parameter int BANK_SEL_WIDTH = $clog2(BANK_NUM),
    parameter int ROW_WIDTH      = ADDR_WIDTH - BANK_SEL_WIDTH,
    parameter int DATA_WIDTH     = VRF_DATA_WIDTH,
    parameter int ARB_MODE       = ARB_RR
) (
    input  logic                                                      clk,
    input  logic                                                      rst_n,
    input  logic [PORT_NUM-1:0]                                       req_valid,
    input  logic [PORT_NUM-1:0][ADDR_WIDTH-1:0]                       req_addr,
    output logic [PORT_NUM-1:0]                                       req_ready,
    output logic [BANK_NUM-1:0][BANK_READ_PORT-1:0]                   bank_rd_en,
    output logic [BANK_NUM-1:0][BANK_READ_PORT-1:0][ROW_WIDTH-1:0]    bank_rd_row,
    input  logic [BANK_NUM-1:0][BANK_READ_PORT-1:0][DATA_WIDTH-1:0]   bank_rd_data,
    output logic [PORT_NUM-1:0]                                       rsp_valid,
    output logic [PORT_NUM-1:0][DATA_WIDTH-1:0]                       rsp_data
);

    localparam int PTR_WIDTH     = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int SLOT_ID_WIDTH = VRF_SLOT_ID_WIDTH;

    logic [PORT_NUM-1:0][BANK_SEL_WIDTH-1:0]                port_bank;
    logic [PORT_NUM-1:0][ROW_WIDTH-1:0]                     port_row;
    logic [BANK_NUM-1:0][PORT_NUM-1:0]                      bank_hit;
    logic [BANK_NUM-1:0][PORT_NUM-1:0]                      bank_grant;
    logic [BANK_NUM-1:0][PORT_NUM-1:0][SLOT_ID_WIDTH-1:0]   bank_slot_id;
    logic [BANK_NUM-1:0][BANK_READ_PORT-1:0]                slot_en;
    logic [BANK_NUM-1:0][BANK_READ_PORT-1:0][ROW_WIDTH-1:0] slot_row;
    logic [BANK_NUM-1:0][PTR_WIDTH-1:0]                     ptr_reg;
    logic [BANK_NUM-1:0][PTR_WIDTH-1:0]                     ptr_next;

    // Route of each port: s0 is this cycle's grant, s1 travels with the bank
    // read enable, s2 lines up with bank_rd_data.
    route_t [PORT_NUM-1:0] route_s0;
    route_t [PORT_NUM-1:0] route_s1;
    route_t [PORT_NUM-1:0] route_s2;

    genvar gi, gj;

    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_addr_split
            assign port_bank[gi] = req_addr[gi][BANK_SEL_WIDTH-1:0];
            assign port_row[gi]  = req_addr[gi][ADDR_WIDTH-1:BANK_SEL_WIDTH];
        end

        for (gi = 0; gi < BANK_NUM; gi++) begin : g_bank
            // Only valid requests addressed to this bank enter its arbitration,
            // so other banks' requesters never affect this bank's grants.
            for (gj = 0; gj < PORT_NUM; gj++) begin : g_hit
                assign bank_hit[gi][gj] = req_valid[gj] &&
                                          (port_bank[gj] == BANK_SEL_WIDTH'(gi));
            end

            vrf_bank_slot_alloc #(
                .PORT_NUM       (PORT_NUM),
                .BANK_READ_PORT (BANK_READ_PORT),
                .ROW_WIDTH      (ROW_WIDTH),
                .SLOT_ID_WIDTH  (SLOT_ID_WIDTH),
                .PTR_WIDTH      (PTR_WIDTH),
                .ARB_MODE       (ARB_MODE)
            ) u_alloc (
                .hit      (bank_hit[gi]),
                .row      (port_row),
                .ptr      (ptr_reg[gi]),
                .grant    (bank_grant[gi]),
                .slot_id  (bank_slot_id[gi]),
                .slot_en  (slot_en[gi]),
                .slot_row (slot_row[gi]),
                .ptr_next (ptr_next[gi])
            );

            // Fixed-priority mode never moves the pointer away from port 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_reg[gi] <= '0;
                end else if (ARB_MODE == ARB_RR) begin
                    ptr_reg[gi] <= ptr_next[gi];
                end
            end

            // Slot read enables; an idle slot keeps its last row.
            for (gj = 0; gj < BANK_READ_PORT; gj++) begin : g_slot_reg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        bank_rd_en[gi][gj]  <= 1'b0;
                        bank_rd_row[gi][gj] <= '0;
                    end else begin
                        bank_rd_en[gi][gj] <= slot_en[gi][gj];
                        if (slot_en[gi][gj]) begin
                            bank_rd_row[gi][gj] <= slot_row[gi][gj];
                        end
                    end
                end
            end
        end
    endgenerate

    // A port hits at most one bank, so OR-ing across banks picks its grant.
    always_comb begin
        route_s0  = '0;
        req_ready = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            route_s0[p].bank = port_bank[p];
            for (int b = 0; b < BANK_NUM; b++) begin
                if (bank_grant[b][p]) begin
                    req_ready[p]      = 1'b1;
                    route_s0[p].valid = 1'b1;
                    route_s0[p].slot  = bank_slot_id[b][p];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_rsp
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    route_s1[gi]  <= '0;
                    route_s2[gi]  <= '0;
                    rsp_valid[gi] <= 1'b0;
                    rsp_data[gi]  <= '0;
                end else begin
                    route_s1[gi]  <= route_s0[gi];
                    route_s2[gi]  <= route_s1[gi];
                    rsp_valid[gi] <= route_s2[gi].valid;
                    if (route_s2[gi].valid) begin
                        rsp_data[gi] <= bank_rd_data[route_s2[gi].bank][route_s2[gi].slot];
                    end
                end
            end
        end
    endgenerate

endmodule
